// File: rtl/sha256_host_pkg.sv
// Shared types and helpers for the SHA-256 self-test host.
// Combinational helpers only; no latency and no flow control.
package sha256_host_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WRITE_MSG = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_READ_ADDR = 3'd4;
    localparam state_t ST_READ_WAIT = 3'd5;
    localparam state_t ST_OUTPUT    = 3'd6;

    localparam int HASH_WORDS         = 8;
    localparam int START_PULSE_CYCLES = 2;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

endpackage

// File: rtl/sha256_msg_gen.sv
// Message word source: seed, then successive rotate-left-1 words, last word forced to zero.
// next_word is combinational from load/advance; no flow control, the caller paces it.
module sha256_msg_gen
    import sha256_host_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        advance,
    input  logic        zero_next,
    output logic [31:0] next_word
);

    logic [31:0] rot_q;
    logic [31:0] rot_d;

    // rot_q keeps rotating even across the zeroed last word; it is reloaded on every go.
    always_comb begin
        rot_d     = rot_q;
        next_word = 32'h0;
        if (load) begin
            rot_d     = seed;
            next_word = seed;
        end else if (advance) begin
            rot_d     = rotl1(rot_q);
            next_word = zero_next ? 32'h0 : rotl1(rot_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rot_q <= 32'h0;
        end else begin
            rot_q <= rot_d;
        end
    end

endmodule

// File: rtl/sha256_host_seq.sv
// Self-test host: writes a seeded message, starts the core, waits for done, streams 8 hash words.
// Hash words leave 3 cycles apart; hash_valid holds its word until hash_ready.
module sha256_host_seq
    import sha256_host_pkg::*;
#(
    parameter int          NUM_OF_WORDS   = 20,
    parameter logic [15:0] MSG_ADDR       = 16'd0,
    parameter logic [15:0] OUT_ADDR       = 16'd1000,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        err,
    output logic [31:0] cycle_count,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        sha_start,
    output logic [15:0] sha_message_addr,
    output logic [15:0] sha_output_addr,
    input  logic        sha_done,
    output logic        hash_valid,
    input  logic        hash_ready,
    output logic [31:0] hash_data,
    output logic [2:0]  hash_idx,
    output logic        hash_last
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        mem_sel_q, mem_sel_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        sha_start_q, sha_start_d;
    logic [15:0] sha_message_addr_q, sha_message_addr_d;
    logic [15:0] sha_output_addr_q, sha_output_addr_d;
    logic        hash_valid_q, hash_valid_d;
    logic [31:0] hash_data_q, hash_data_d;
    logic [2:0]  hash_idx_q, hash_idx_d;
    logic        hash_last_q, hash_last_d;

    logic        msg_load, msg_advance, msg_zero_next;
    logic [31:0] msg_word;

    sha256_msg_gen u_msg_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed      (seed),
        .load      (msg_load),
        .advance   (msg_advance),
        .zero_next (msg_zero_next),
        .next_word (msg_word)
    );

    // cnt_q is reused per phase: word index, start pulse, wait timer, hash word index.
    assign msg_zero_next = (cnt_q == 32'(NUM_OF_WORDS - 2));

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        busy_d             = busy_q;
        err_d              = err_q;
        cycle_count_d      = cycle_count_q;
        mem_sel_d          = mem_sel_q;
        mem_we_d           = mem_we_q;
        mem_addr_d         = mem_addr_q;
        mem_write_data_d   = mem_write_data_q;
        sha_start_d        = sha_start_q;
        sha_message_addr_d = sha_message_addr_q;
        sha_output_addr_d  = sha_output_addr_q;
        hash_valid_d       = hash_valid_q;
        hash_data_d        = hash_data_q;
        hash_idx_d         = hash_idx_q;
        hash_last_d        = hash_last_q;
        msg_load           = 1'b0;
        msg_advance        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d            = ST_WRITE_MSG;
                    cnt_d              = 32'd0;
                    busy_d             = 1'b1;
                    err_d              = 1'b0;
                    cycle_count_d      = 32'd0;
                    mem_sel_d          = 1'b1;
                    mem_we_d           = 1'b1;
                    mem_addr_d         = MSG_ADDR;
                    msg_load           = 1'b1;
                    mem_write_data_d   = msg_word;
                    sha_message_addr_d = MSG_ADDR;
                    sha_output_addr_d  = OUT_ADDR;
                end
            end
            ST_WRITE_MSG: begin
                if (cnt_q == 32'(NUM_OF_WORDS - 1)) begin
                    state_d          = ST_START;
                    cnt_d            = 32'd0;
                    mem_sel_d        = 1'b0;
                    mem_we_d         = 1'b0;
                    mem_addr_d       = 16'd0;
                    mem_write_data_d = 32'h0;
                    sha_start_d      = 1'b1;
                end else begin
                    msg_advance      = 1'b1;
                    cnt_d            = cnt_q + 32'd1;
                    mem_addr_d       = mem_addr_q + 16'd1;
                    mem_write_data_d = msg_word;
                end
            end
            ST_START: begin
                cycle_count_d = cycle_count_q + 32'd1;
                if (cnt_q == 32'(START_PULSE_CYCLES - 1)) begin
                    state_d     = ST_WAIT_DONE;
                    cnt_d       = 32'd0;
                    sha_start_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_WAIT_DONE: begin
                cycle_count_d = cycle_count_q + 32'd1;
                if (sha_done) begin
                    state_d    = ST_READ_ADDR;
                    cnt_d      = 32'd0;
                    mem_sel_d  = 1'b1;
                    mem_addr_d = OUT_ADDR;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_READ_ADDR: begin
                state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                state_d      = ST_OUTPUT;
                hash_valid_d = 1'b1;
                hash_data_d  = mem_read_data;
                hash_idx_d   = cnt_q[2:0];
                hash_last_d  = (cnt_q == 32'(HASH_WORDS - 1));
            end
            ST_OUTPUT: begin
                if (hash_ready) begin
                    hash_valid_d = 1'b0;
                    hash_last_d  = 1'b0;
                    if (cnt_q == 32'(HASH_WORDS - 1)) begin
                        state_d    = ST_IDLE;
                        cnt_d      = 32'd0;
                        busy_d     = 1'b0;
                        mem_sel_d  = 1'b0;
                        mem_addr_d = 16'd0;
                    end else begin
                        state_d    = ST_READ_ADDR;
                        cnt_d      = cnt_q + 32'd1;
                        mem_addr_d = mem_addr_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            cnt_q              <= 32'd0;
            busy_q             <= 1'b0;
            err_q              <= 1'b0;
            cycle_count_q      <= 32'd0;
            mem_sel_q          <= 1'b0;
            mem_we_q           <= 1'b0;
            mem_addr_q         <= 16'd0;
            mem_write_data_q   <= 32'h0;
            sha_start_q        <= 1'b0;
            sha_message_addr_q <= 16'd0;
            sha_output_addr_q  <= 16'd0;
            hash_valid_q       <= 1'b0;
            hash_data_q        <= 32'h0;
            hash_idx_q         <= 3'd0;
            hash_last_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            busy_q             <= busy_d;
            err_q              <= err_d;
            cycle_count_q      <= cycle_count_d;
            mem_sel_q          <= mem_sel_d;
            mem_we_q           <= mem_we_d;
            mem_addr_q         <= mem_addr_d;
            mem_write_data_q   <= mem_write_data_d;
            sha_start_q        <= sha_start_d;
            sha_message_addr_q <= sha_message_addr_d;
            sha_output_addr_q  <= sha_output_addr_d;
            hash_valid_q       <= hash_valid_d;
            hash_data_q        <= hash_data_d;
            hash_idx_q         <= hash_idx_d;
            hash_last_q        <= hash_last_d;
        end
    end

    assign busy             = busy_q;
    assign err              = err_q;
    assign cycle_count      = cycle_count_q;
    assign mem_sel          = mem_sel_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_write_data   = mem_write_data_q;
    assign sha_start        = sha_start_q;
    assign sha_message_addr = sha_message_addr_q;
    assign sha_output_addr  = sha_output_addr_q;
    assign hash_valid       = hash_valid_q;
    assign hash_data        = hash_data_q;
    assign hash_idx         = hash_idx_q;
    assign hash_last        = hash_last_q;

endmodule

// File: tb/tb_sha256_host_seq.sv
// Bench for sha256_host_seq: shared memory, a simple core model and a per-cycle checker.
`timescale 1ns/1ps
module tb_sha256_host_seq;

    localparam int          N    = 20;
    localparam logic [15:0] MSGA = 16'd0;
    localparam logic [15:0] OUTA = 16'd1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        go, hash_ready, sha_done;
    logic [31:0] seed, mem_read_data;
    logic        busy, err, mem_sel, mem_we, sha_start, hash_valid, hash_last;
    logic [31:0] cycle_count, mem_write_data, hash_data;
    logic [15:0] mem_addr, sha_message_addr, sha_output_addr;
    logic [2:0]  hash_idx;

    logic        go_t, hash_ready_t, sha_done_t;
    logic [31:0] seed_t, mem_read_data_t;
    logic        busy_t, err_t, mem_sel_t, mem_we_t, sha_start_t, hash_valid_t, hash_last_t;
    logic [31:0] cycle_count_t, mem_write_data_t, hash_data_t;
    logic [15:0] mem_addr_t, sha_message_addr_t, sha_output_addr_t;
    logic [2:0]  hash_idx_t;

    sha256_host_seq #(.NUM_OF_WORDS(N), .MSG_ADDR(MSGA), .OUT_ADDR(OUTA), .TIMEOUT_CYCLES(1000)) u_dut (
        .clk(clk), .reset_n(reset_n), .go(go), .seed(seed), .busy(busy), .err(err),
        .cycle_count(cycle_count), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .sha_start(sha_start),
        .sha_message_addr(sha_message_addr), .sha_output_addr(sha_output_addr), .sha_done(sha_done),
        .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_data(hash_data),
        .hash_idx(hash_idx), .hash_last(hash_last)
    );

    sha256_host_seq #(.NUM_OF_WORDS(N), .MSG_ADDR(MSGA), .OUT_ADDR(OUTA), .TIMEOUT_CYCLES(100)) u_dut_to (
        .clk(clk), .reset_n(reset_n), .go(go_t), .seed(seed_t), .busy(busy_t), .err(err_t),
        .cycle_count(cycle_count_t), .mem_sel(mem_sel_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t),
        .mem_write_data(mem_write_data_t), .mem_read_data(mem_read_data_t), .sha_start(sha_start_t),
        .sha_message_addr(sha_message_addr_t), .sha_output_addr(sha_output_addr_t), .sha_done(sha_done_t),
        .hash_valid(hash_valid_t), .hash_ready(hash_ready_t), .hash_data(hash_data_t),
        .hash_idx(hash_idx_t), .hash_last(hash_last_t)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference message: word i is seed rotated left by i, the final word is zero.
    function automatic logic [31:0] model_word(input logic [31:0] s, input int i);
        logic [63:0] d;
        if (i == N - 1) return 32'h0;
        d = {s, s} << (i % 32);
        return d[63:32];
    endfunction

    // Shared memory with the external ownership mux.
    logic [31:0] mem [0:65535];
    logic        core_we;
    logic [15:0] core_addr;
    logic [31:0] core_data;
    always @(posedge clk) begin
        if (mem_sel && mem_we) mem[mem_addr] <= mem_write_data;
        else if (!mem_sel && core_we) mem[core_addr] <= core_data;
        mem_read_data <= mem[mem_addr];
    end

    // Core model: writes 8 result words, raises done core_delay cycles after start rises.
    logic        core_done, spur_done, early_done;
    int          core_delay;
    logic [31:0] exp_hash [0:7];
    assign sha_done = core_done | spur_done;

    initial begin
        logic [31:0] x;
        core_done = 1'b0; core_we = 1'b0; core_addr = 16'd0; core_data = 32'h0;
        forever begin
            @(posedge sha_start);
            #1;
            x = 32'h0;
            for (int i = 0; i < N; i++) x ^= mem[MSGA + 16'(i)];
            for (int k = 0; k < 8; k++) exp_hash[k] = (x ^ 32'h6a09e667) + 32'(k) * 32'h9e3779b9;
            for (int c = 1; c <= core_delay; c++) begin
                tick();
                core_done = (early_done && c == 1) || (c == core_delay);
                core_we   = (c >= 3 && c < 11);
                if (c >= 3 && c < 11) begin
                    core_addr = OUTA + 16'(c - 3);
                    core_data = exp_hash[c - 3];
                end
            end
            tick();
            core_done = 1'b0;
            core_we   = 1'b0;
        end
    end

    // Per-cycle checker against the transaction-level model.
    int          cyc = 0;
    logic [31:0] cur_seed = 32'h0;
    bit          m_busy = 1'b0;
    int          exp_w = 0, exp_j = 0, n_xfer = 0, start_hi = 0, last_xfer_cyc = 0;
    bit          prev_valid = 1'b0;
    bit          hv_t_seen = 1'b0;
    logic [31:0] cap [0:N-1];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (hash_valid_t) hv_t_seen = 1'b1;
            if (!reset_n) begin
                chk("reset_flags", 32'({busy, err, mem_sel, mem_we, sha_start, hash_valid, hash_last}), 32'h0);
                chk("reset_addr", 32'(mem_addr), 32'h0);
                m_busy = 1'b0; exp_w = 0; exp_j = 0; n_xfer = 0; start_hi = 0;
            end else begin
                chk("busy", 32'(busy), 32'(m_busy));
                if (mem_sel && mem_we) begin
                    chk("wr_addr", 32'(mem_addr), 32'(MSGA + 16'(exp_w)));
                    chk("wr_data", mem_write_data, model_word(cur_seed, exp_w));
                    if (exp_w < N) cap[exp_w] = mem_write_data;
                    exp_w++;
                end
                if (sha_start) begin
                    start_hi++;
                    chk("start_mem_owner", 32'({mem_sel, mem_we}), 32'h0);
                end
                if (hash_valid) begin
                    chk("hash_idx", 32'(hash_idx), 32'(exp_j % 8));
                    chk("hash_data", hash_data, exp_hash[exp_j % 8]);
                    chk("hash_last", 32'(hash_last), 32'(exp_j == 7));
                    if (!prev_valid && n_xfer > 0) chk("hash_gap", 32'(cyc - last_xfer_cyc), 32'd3);
                    if (hash_ready) begin
                        n_xfer++;
                        last_xfer_cyc = cyc;
                        exp_j++;
                        if (exp_j == 8) m_busy = 1'b0;
                    end
                end else begin
                    chk("last_without_valid", 32'(hash_last), 32'h0);
                end
                if (go && !m_busy) begin
                    m_busy = 1'b1; cur_seed = seed;
                    exp_w = 0; exp_j = 0; n_xfer = 0; start_hi = 0;
                end
            end
            prev_valid = hash_valid;
        end
    end

    task automatic run(input logic [31:0] s, input int dly, input bit stall, input bit noise);
        bit fin = 1'b0;
        bit stalled = 1'b0;
        seed = s; core_delay = dly; early_done = noise;
        go = 1'b1; tick(); go = 1'b0;
        if (noise) begin
            repeat (5) tick();
            spur_done = 1'b1; tick(); spur_done = 1'b0;
            repeat (40) tick();
            go = 1'b1; tick(); go = 1'b0;
        end
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (stall && !stalled && hash_valid && hash_idx == 3'd3) begin
                hash_ready = 1'b0;
                repeat (5) tick();
                hash_ready = 1'b1;
                stalled = 1'b1;
            end
            tick();
            if (!busy) fin = 1'b1;
        end
        chk("run_completes", 32'(fin), 32'h1);
        chk("words_out", 32'(n_xfer), 32'd8);
        chk("start_cycles", 32'(start_hi), 32'd2);
        chk("cycle_count", cycle_count, 32'(dly + 1));
        chk("err_clear", 32'(err), 32'h0);
    endtask

    initial begin
        int t0, te;
        go = 1'b0; seed = 32'h0; hash_ready = 1'b1; spur_done = 1'b0; early_done = 1'b0; core_delay = 130;
        go_t = 1'b0; seed_t = 32'hcafef00d; hash_ready_t = 1'b1; sha_done_t = 1'b0; mem_read_data_t = 32'h0;
        repeat (3) tick();
        chk("reset_cycle_count", cycle_count, 32'h0);
        chk("reset_sha_addrs", {sha_message_addr, sha_output_addr}, 32'h0);
        chk("reset_hash_data", hash_data, 32'h0);
        reset_n = 1'b1;
        tick();

        run(32'h01234567, 130, 1'b1, 1'b0);
        chk("model_w18", model_word(32'h01234567, 18), 32'h159c048d);
        chk("word0", cap[0], 32'h01234567);
        chk("word1", cap[1], 32'h02468ace);
        chk("word2", cap[2], 32'h048d159c);
        chk("word18", cap[18], 32'h159c048d);
        chk("word19", cap[19], 32'h00000000);
        chk("cycle_count_131", cycle_count, 32'd131);
        chk("sha_output_addr", 32'(sha_output_addr), 32'd1000);
        chk("sha_message_addr", 32'(sha_message_addr), 32'd0);

        run(32'hdeadbeef, 60, 1'b0, 1'b1);

        seed = 32'h89abcdef;
        go = 1'b1; tick(); go = 1'b0;
        repeat (7) tick();
        chk("pre_reset_addr7", 32'(mem_addr), 32'd7);
        reset_n = 1'b0;
        #1;
        chk("midreset_flags", 32'({busy, err, mem_sel, mem_we, sha_start, hash_valid, hash_last}), 32'h0);
        chk("midreset_bus", mem_write_data | 32'(mem_addr) | cycle_count, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        run(32'h89abcdef, 40, 1'b0, 1'b0);
        chk("restart_word0", cap[0], 32'h89abcdef);

        t0 = -1; te = -1;
        go_t = 1'b1; tick(); go_t = 1'b0;
        for (int c = 0; c < 400 && te < 0; c++) begin
            tick();
            if (sha_start_t && t0 < 0) t0 = c;
            if (err_t) te = c;
        end
        chk("timeout_err", 32'(err_t), 32'h1);
        chk("timeout_latency", 32'(te - t0), 32'd102);
        chk("timeout_busy", 32'(busy_t), 32'h0);
        repeat (3) tick();
        chk("timeout_err_sticky", 32'(err_t), 32'h1);
        chk("timeout_no_hash", 32'(hv_t_seen), 32'h0);
        go_t = 1'b1; tick(); go_t = 1'b0;
        chk("timeout_err_cleared", 32'(err_t), 32'h0);
        chk("timeout_rego_busy", 32'(busy_t), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_host_seq.md
Name: sha256_host_seq

Overview:
Hardware host for the simplified SHA-256 co-processor. On a single `go` command it:
- owns the shared word memory and writes a seed-derived padded-input message of NUM_OF_WORDS words at MSG_ADDR;
- hands the memory to the core and pulses `sha_start`;
- waits for `sha_done`;
- reads the 8 hash words back from OUT_ADDR and streams them out on a valid/ready port.

It is the reader of the core's result writes and the driver of its start/done handshake. It replaces the behavioural host for on-chip self-test.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words (>=2)
MSG_ADDR, 16'd0, base address of message
OUT_ADDR, 16'd1000, base address where core writes H0..H7
TIMEOUT_CYCLES, 65535, max cycles allowed in WAIT_DONE

Ports:
clk  in  1  single clock; also the memory clock
reset_n  in  1  asynchronous active-low reset
go  in  1  command pulse; sampled only in IDLE
seed  in  32  message seed; captured on accepted go
busy  out  1  high from accepted go until return to IDLE
err  out  1  timeout flag; sticky until next accepted go
cycle_count  out  32  cycles from sha_start rise to sha_done (inclusive); frozen after done
mem_sel  out  1  1 = host owns memory port, 0 = core owns it (external mux)
mem_we  out  1  host write enable
mem_addr  out  16  host address
mem_write_data  out  32  host write data
mem_read_data  in  32  memory read data; valid one edge after the edge that sampled mem_addr
sha_start  out  1  start to core
sha_message_addr  out  16  constant MSG_ADDR
sha_output_addr  out  16  constant OUT_ADDR
sha_done  in  1  done from core
hash_valid  out  1  hash word valid
hash_ready  in  1  consumer ready
hash_data  out  32  hash word
hash_idx  out  3  word index 0..7
hash_last  out  1  high with idx 7

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Reset mid-operation: immediately return to IDLE with all outputs 0. The core is reset by the same `reset_n`.
- All outputs are registered.

State machine:
- IDLE
  - `go` goes to WRITE_MSG.
  - On `go`: capture `seed`; set busy=1; clear err and cycle_count.
- WRITE_MSG
  - Runs for NUM_OF_WORDS cycles with mem_sel=1 and mem_we=1.
  - mem_addr = MSG_ADDR + i.
  - Data: word0 = seed; word i = rotate-left-1 of word i-1 for 1 <= i <= NUM_OF_WORDS-2; last word = 32'h0.
  - Address arithmetic is 16-bit with wrap-around.
  - After the last word: mem_we=0, mem_sel=0, go to START.
- START
  - sha_start=1 for exactly 2 cycles, then WAIT_DONE.
  - cycle_count increments on every cycle from the first sha_start cycle onward.
- WAIT_DONE
  - mem_sel=0, cycle_count increments.
  - sha_done=1 goes to READ_ADDR with cycle_count frozen.
  - If TIMEOUT_CYCLES elapse in WAIT_DONE: err=1, go to IDLE (busy=0), no hash output.
- READ_ADDR
  - mem_sel=1, mem_we=0, mem_addr = OUT_ADDR + j, then READ_WAIT.
- READ_WAIT
  - One cycle.
  - At its end, capture mem_read_data into hash_data, set hash_idx=j, hash_valid=1, go to OUTPUT.
- OUTPUT
  - hash_valid holds and hash_data/idx/last stay stable until hash_valid & hash_ready.
  - On transfer: if j<7, go to READ_ADDR with j+1; else go to IDLE and set busy=0, mem_sel=0.
- `go` outside IDLE is ignored.
- `sha_done` outside WAIT_DONE is ignored.
- A done arriving during START is ignored.
- `hash_ready` held high gives one word per 3 cycles.

Decomposition:
- Package sha256_host_pkg: state enum typedef; ROTL1 function; constants HASH_WORDS=8 and START_PULSE_CYCLES=2.
- One sub-module is natural: sha256_msg_gen, which takes seed, load and advance, and produces the current message word (rotate register plus last-word zeroing).
- The FSM, counters and output register stay in the top.

Test Plan:
- Seed 32'h01234567, NUM_OF_WORDS=20 -> writes at addr 0..19 with data:
  - 01234567, 02468ace, 048d159c, ...
  - word18 = rotl18(seed) = 159c048d
  - word19 = 00000000
  - then sha_start high exactly 2 cycles, mem_sel=0.
- Core model raises done 130 cycles after start rise -> cycle_count=131. Reads at 1000..1007 and streams 8 words matching the memory contents; hash_last only on idx 7.
- hash_ready low for 5 cycles on idx 3 -> hash_data/idx stable throughout, no word lost or duplicated, busy stays 1.
- TIMEOUT_CYCLES=100 and done never asserted -> err=1 after 100 WAIT_DONE cycles, busy=0, hash_valid never asserted. The next go clears err.
- go pulsed during WAIT_DONE, plus a spurious sha_done during WRITE_MSG -> both ignored; the sequence completes normally.
- reset_n low during WRITE_MSG word 7 -> all outputs 0 immediately. After release, go restarts at MSG_ADDR word 0.
